disp_page_sched: RTL
====================

# disp_page_sched

Display-page scheduler that shares the board's 4-digit seven-segment display among several 32-bit observation sources of `mips_soc`: GPO2, PC, instruction and ALU result. It selects one 16-bit half-word per cycle under software, push-button or timed auto-rotate control. Its output feeds the existing hex-to-seven-segment decoders and LED multiplexer in `mips_fpga`, replacing the fixed GPO2 low/high selection.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a button level.
- `ROTATE_CYCLES`, default 100000000: cycles per page in AUTO mode; must be ≥2.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `btn_next`, in, 1: raw asynchronous push-button, active-high.
- `mode`, in, 2: 0 = SOFT, 1 = MANUAL, 2 = AUTO, 3 is treated as SOFT.
- `soft_sel`, in, 1: software half select (gpo1[4]); used only in SOFT mode.
- `gpo2`, `pc_current`, `instr`, `alu_out`, in, 32 each: observation sources.
- `disp_hex`, out, 16: registered half-word to display.
- `page`, out, 3: current page index, registered.
- `page_tick`, out, 1: one-cycle pulse on the cycle `page` takes a new value.

## Operation
- Pages:
  - 0 = gpo2[15:0], 1 = gpo2[31:16].
  - 2 = pc_current[15:0], 3 = pc_current[31:16].
  - 4 = instr[15:0], 5 = instr[31:16].
  - 6 = alu_out[15:0], 7 = alu_out[31:16].
- Button path:
  - 2-flop synchronizer, then debouncer.
  - The debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
  - A debounced 0→1 transition produces a one-cycle `btn_pulse`. Release produces nothing.
- SOFT mode:
  - `page` <= {2'b00, soft_sel} every cycle.
  - `btn_pulse` is ignored; the rotate timer is held at 0.
- MANUAL mode:
  - `btn_pulse` advances `page` by 1, wrapping 7→0.
  - The timer is held at 0.
- AUTO mode:
  - The timer counts 0..ROTATE_CYCLES-1. At terminal count it wraps to 0 and `page` advances by 1.
  - A `btn_pulse` also advances `page` and restarts the timer at 0.
  - If `btn_pulse` and terminal count occur in the same cycle, advance by exactly 1; the timer goes to 0.
- Mode change:
  - `mode` is sampled every cycle with no synchronizer; it is a quasi-static switch input and is synchronized upstream.
  - On any change of the decoded mode the timer clears to 0.
  - Entering MANUAL or AUTO keeps the current `page`. Entering SOFT takes `soft_sel` on the next edge.
- `page_tick` is high for the cycle in which the registered `page` differs from its previous value. It is never asserted for a same-value update.

## Timing
- Reset (async assert, synchronous release via `clk` domain flops): `page` = 0, `disp_hex` = 16'h0000, `page_tick` = 0, timer = 0, debounced level = 0, synchronizer = 0.
- Reset asserted mid-count or mid-debounce discards all progress; no pulse is generated on release.
- `disp_hex`(t+1) = slice(`page`(t), sources(t)). The sources are live, so the display tracks them with 1-cycle latency.
- After a page-change edge k, `disp_hex` shows the new page at edge k+1.
- Button to page latency: 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 cycles from a stable press to the `page` update.
- In AUTO, with no button activity, `page` advances every `ROTATE_CYCLES` cycles exactly.

## Structure
- Shared package `mips_disp_pkg`:
  - `disp_mode_e` (SOFT, MANUAL, AUTO).
  - `disp_page_e` (8 entries above).
  - Width constant `DISP_PAGE_W` = 3.
- Sub-module `btn_debounce`, parameterized by `DEBOUNCE_CYCLES`. It contains the synchronizer, counter and rising-edge pulse generator, and is reusable for future board buttons.
- Top body: mode decode, rotate timer, page register, and a 8:1 × 16-bit output mux register.

## Test plan
Use `DEBOUNCE_CYCLES` = 4 and `ROTATE_CYCLES` = 8.
- Reset: assert `rst_n`=0 mid-operation, at no clock edge → `page`=0, `disp_hex`=0, `page_tick`=0 immediately. Sources gpo2=32'hABCD1234 after release in SOFT with soft_sel=0 → `disp_hex`=16'h1234; set soft_sel=1 → next page 1, `disp_hex`=16'hABCD one cycle later, one `page_tick`.
- MANUAL debounce: pulse btn high 3 cycles then low (bounce) → no change. Hold high 10 cycles → `page` 0→1 exactly once, 7 cycles after the rising edge. Eight clean presses → `page` wraps back to 1.
- AUTO rotate: pc_current=32'h0040_0010, start at page 2 → `page` 3 after 8 cycles, `disp_hex`=16'h0040. Page 7→0 wraps with `page_tick` each step.
- AUTO collision: align `btn_pulse` with terminal count → `page` advances by 1 only; next advance occurs 8 cycles later.
- Mode change: switch AUTO→MANUAL at timer=5 → no further advances. Switch back to AUTO → next advance after a full 8 cycles. Set `mode`=3 → SOFT behaviour.

Source files
------------

// File: rtl/mips_disp_pkg.sv
// mips_disp_pkg
// Shared types for the seven-segment display page scheduler of the
// mips_fpga board wrapper.
//   disp_mode_e  : page selection policy (software, push-button, timed)
//   disp_page_e  : which 16-bit half of which observation source is shown
//   DISP_PAGE_W  : width of a page index
//   decodeMode() : folds the raw 2-bit mode switch onto disp_mode_e
package mips_disp_pkg;

    localparam int DISP_PAGE_W = 3;

    typedef enum logic [1:0] {
        MODE_SOFT   = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_AUTO   = 2'd2
    } disp_mode_e;

    typedef enum logic [DISP_PAGE_W-1:0] {
        PAGE_GPO2_LO  = 3'd0,
        PAGE_GPO2_HI  = 3'd1,
        PAGE_PC_LO    = 3'd2,
        PAGE_PC_HI    = 3'd3,
        PAGE_INSTR_LO = 3'd4,
        PAGE_INSTR_HI = 3'd5,
        PAGE_ALU_LO   = 3'd6,
        PAGE_ALU_HI   = 3'd7
    } disp_page_e;

    // The unused switch code 3 behaves like software control so a stray
    // setting never leaves the display frozen on a random page.
    function automatic disp_mode_e decodeMode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_MANUAL;
            2'd2:    return MODE_AUTO;
            default: return MODE_SOFT;
        endcase
    endfunction

endpackage

// File: rtl/disp_page_sched_if.sv
// disp_page_sched_if
// Bundles the observation sources coming from the SoC and the page /
// half-word outputs going to the hex decoders and LED multiplexer.
//   gpo2, pc_current, instr, alu_out : 32-bit observation sources
//   disp_hex                         : half-word to display
//   page                             : current page index
//   page_tick                        : one-cycle pulse on a page change
// Modports:
//   master : SoC / board side, drives the sources and reads the display
//   slave  : scheduler side, reads the sources and drives the display
interface disp_page_sched_if;
    import mips_disp_pkg::*;

    logic [31:0]            gpo2;
    logic [31:0]            pc_current;
    logic [31:0]            instr;
    logic [31:0]            alu_out;
    logic [15:0]            disp_hex;
    logic [DISP_PAGE_W-1:0] page;
    logic                   page_tick;

    modport master (
        output gpo2,
        output pc_current,
        output instr,
        output alu_out,
        input  disp_hex,
        input  page,
        input  page_tick
    );

    modport slave (
        input  gpo2,
        input  pc_current,
        input  instr,
        input  alu_out,
        output disp_hex,
        output page,
        output page_tick
    );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce
// Cleans up a raw mechanical push-button for use in the clk domain.
// A two-flop synchronizer feeds a stability counter: the debounced level
// only follows the synchronized input once the two have disagreed for
// DEBOUNCE_CYCLES consecutive cycles, and any bounce back restarts the
// count. An accepted press yields a single-cycle pulse; release yields
// nothing. Written to be reused for any other board button.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   btnRaw_i    raw asynchronous push-button, active-high
//   btnPulse_o  one-cycle pulse per accepted press
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnRaw_i,
    output logic btnPulse_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncMeta_q;
    logic             syncOut_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             pulse_q;
    logic             pulse_d;

    // Two-flop synchronizer. The first stage may go metastable; only the
    // second stage is looked at by the rest of the logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
        end else begin
            syncMeta_q <= btnRaw_i;
            syncOut_q  <= syncMeta_q;
        end
    end

    // Stability counter. The count runs only while the synchronized input
    // disagrees with the accepted level; on the last disagreeing cycle the
    // level flips and, if it flipped high, the press pulse is armed.
    always_comb begin
        level_d = level_q;
        count_d = '0;
        pulse_d = 1'b0;
        if (syncOut_q != level_q) begin
            if (count_q == CNT_LAST) begin
                level_d = syncOut_q;
                pulse_d = syncOut_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Debounced level, counter and registered press pulse. Reset drops any
    // partial count, so releasing reset can never emit a pulse by itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            level_q <= level_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign btnPulse_o = pulse_q;

endmodule

// File: rtl/disp_page_sched.sv
// disp_page_sched
// Shares the 4-digit seven-segment display between the 32-bit observation
// sources of mips_soc. Each cycle one 16-bit half-word is selected by
// page: software-selected (SOFT), stepped by a debounced push-button
// (MANUAL) or stepped by a rotate timer plus the button (AUTO).
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   btn_next  raw push-button, active-high, advances the page
//   mode      0 SOFT, 1 MANUAL, 2 AUTO, 3 behaves as SOFT
//   soft_sel  software half select, only used in SOFT
//   bus       slave side of disp_page_sched_if (sources in, display out)
module disp_page_sched
    import mips_disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ROTATE_CYCLES   = 100000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_next,
    input  logic [1:0]              mode,
    input  logic                    soft_sel,
    disp_page_sched_if.slave        bus
);

    localparam int TMR_W = (ROTATE_CYCLES > 2) ? $clog2(ROTATE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ROTATE_CYCLES - 1);

    disp_mode_e             modeDec;
    logic                   btnPulse;
    logic                   advance;
    logic [TMR_W-1:0]       timer_q;
    logic [TMR_W-1:0]       timer_d;
    logic [DISP_PAGE_W-1:0] page_q;
    logic [DISP_PAGE_W-1:0] page_d;
    logic [15:0]            dispHex_q;
    logic [15:0]            dispHex_d;
    logic                   pageTick_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btnNext (
        .clk        (clk),
        .rst_n      (rst_n),
        .btnRaw_i   (btn_next),
        .btnPulse_o (btnPulse)
    );

    // The mode switch is quasi-static and already synchronized upstream,
    // so it is decoded directly every cycle.
    assign modeDec = decodeMode(mode);

    // Next page and rotate timer. The timer only ever counts in AUTO and
    // is forced to 0 in every other mode, so any change of decoded mode
    // finds it at 0 and entering AUTO always starts a full period. A button
    // pulse landing on terminal count still advances by exactly one.
    always_comb begin
        timer_d = '0;
        page_d  = page_q;
        advance = 1'b0;
        case (modeDec)
            MODE_MANUAL: begin
                advance = btnPulse;
            end
            MODE_AUTO: begin
                advance = btnPulse || (timer_q == TMR_LAST);
                if (!advance) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                advance = 1'b0;
            end
        endcase
        if (modeDec == MODE_SOFT) begin
            page_d = {{(DISP_PAGE_W-1){1'b0}}, soft_sel};
        end else if (advance) begin
            page_d = page_q + DISP_PAGE_W'(1);
        end
    end

    // Half-word select from the page currently registered. The sources are
    // live, so the display follows them one cycle behind.
    always_comb begin
        dispHex_d = bus.gpo2[15:0];
        case (disp_page_e'(page_q))
            PAGE_GPO2_LO:  dispHex_d = bus.gpo2[15:0];
            PAGE_GPO2_HI:  dispHex_d = bus.gpo2[31:16];
            PAGE_PC_LO:    dispHex_d = bus.pc_current[15:0];
            PAGE_PC_HI:    dispHex_d = bus.pc_current[31:16];
            PAGE_INSTR_LO: dispHex_d = bus.instr[15:0];
            PAGE_INSTR_HI: dispHex_d = bus.instr[31:16];
            PAGE_ALU_LO:   dispHex_d = bus.alu_out[15:0];
            PAGE_ALU_HI:   dispHex_d = bus.alu_out[31:16];
            default:       dispHex_d = bus.gpo2[15:0];
        endcase
    end

    // Page, timer and display registers. page_tick is registered alongside
    // page so it is high exactly in the cycle the new page is visible, and
    // never for a same-value reload (e.g. SOFT rewriting the same half).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            page_q     <= '0;
            dispHex_q  <= '0;
            pageTick_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            page_q     <= page_d;
            dispHex_q  <= dispHex_d;
            pageTick_q <= (page_d != page_q);
        end
    end

    assign bus.page      = page_q;
    assign bus.disp_hex  = dispHex_q;
    assign bus.page_tick = pageTick_q;

endmodule
